cpu_loader: RTL and testbench
=============================

Name: cpu_loader

Overview:
- Host-side boot/run/dump controller sitting directly upstream of the cpu top; drives the cpu's external memory ports and its enable input.
- Accepts one framed word stream from the host over valid/ready, then:
  - writes instruction memory and data memory;
  - runs the cpu for a host-given number of cycles;
  - streams back the first DUMP_WORDS data-memory words.
- Replaces testbench-driven memory loading so the cpu can be exercised as a self-contained system.

Parameters:
- DATA_W, 32, word width of stream and memories.
- IMEM_WORDS, 512, instruction memory capacity in words.
- DMEM_WORDS, 1024, data memory capacity in words.
- DUMP_WORDS, 16, data words returned after run; legal range 1..DMEM_WORDS.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset. Reset is synchronous and active-low.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts word.
- s_data  in  DATA_W  host word.
- m_valid  out  1  dump word valid.
- m_ready  in  1  host accepts dump word.
- m_data  out  DATA_W  dump word.
- cpu_enable  out  1  drives cpu enable.
- imem_addr  out  32  cpu addr_ext; byte address = word index*4.
- imem_wen  out  1  cpu wen_ext.
- imem_ren  out  1  cpu ren_ext; tied 0.
- imem_wdata  out  DATA_W  cpu wdata_ext.
- dmem_addr  out  32  cpu addr_ext_2; byte address = word index*4.
- dmem_wen  out  1  cpu wen_ext_2.
- dmem_ren  out  1  cpu ren_ext_2.
- dmem_wdata  out  DATA_W  cpu wdata_ext_2.
- dmem_rdata  in  DATA_W  cpu rdata_ext_2; valid 1 cycle after dmem_ren.
- done  out  1  dump complete; sticky.
- err  out  1  bad header; sticky.

Behaviour:
- Stream frame: NI, NI imem words, ND, ND dmem words, R.
  - NI: 1..IMEM_WORDS.
  - ND: 0..DMEM_WORDS.
  - R: run cycles, 32-bit unsigned.
- A word transfers when s_valid & s_ready. All outputs are registered.
- Reset (arst_n=0 at a clk edge, any state, including mid-load/run/dump):
  - state HDR_I; counters cleared.
  - Outputs 0 except s_ready=1: cpu_enable, wen/ren, m_valid, m_data, addrs, done, err all 0.
  - Memory contents are not cleared.
- FSM:
  - HDR_I (s_ready=1): on transfer latch NI.
    - NI==0 or NI>IMEM_WORDS -> ERROR; else -> LOAD_I.
  - LOAD_I (s_ready=1): each transfer issues one imem write the next cycle.
    - Write: imem_wen=1 for exactly 1 cycle, imem_addr=idx*4, imem_wdata=word.
    - idx increments. After the NIth word -> HDR_D.
    - Back-to-back words give one write per cycle.
  - HDR_D: latch ND. ND>DMEM_WORDS -> ERROR; ND==0 -> HDR_R; else -> LOAD_D.
  - LOAD_D: identical to LOAD_I on the dmem port; after the NDth word -> HDR_R.
  - HDR_R: latch R; s_ready drops the cycle after.
    - R==0 -> DUMP_REQ with cpu_enable never asserted.
    - else -> RUN.
  - RUN (s_ready=0): cpu_enable=1 for exactly R consecutive cycles; down-counter; then cpu_enable=0 -> DUMP_REQ.
  - DUMP_REQ: dmem_ren=1, dmem_addr=k*4 for 1 cycle -> DUMP_CAP.
  - DUMP_CAP: register dmem_rdata into m_data; m_valid=1 -> DUMP_OUT.
  - DUMP_OUT: hold m_valid/m_data stable until m_ready.
    - On handshake m_valid=0, k++.
    - If k==DUMP_WORDS -> DONE, else -> DUMP_REQ.
    - Throughput: 1 word per 3 cycles minimum.
  - DONE: done=1 and s_ready=0 until reset.
  - ERROR: err=1 and s_ready=0 until reset; no memory writes and no cpu_enable.
- s_valid outside HDR/LOAD states is ignored; no state change.
- m_ready outside DUMP_OUT is ignored.
- Never drive imem_wen and dmem_wen in the same cycle.
- Never drive dmem_wen and dmem_ren in the same cycle.
- Index counters are sized $clog2(depth)+1; no wrap-around is possible because headers are range-checked.

Decomposition:
- Shared package cpu_loader_pkg holds:
  - the state enum (HDR_I, LOAD_I, HDR_D, LOAD_D, HDR_R, RUN, DUMP_REQ, DUMP_CAP, DUMP_OUT, DONE, ERROR);
  - the byte-address shift constant (2).
- No sub-module: FSM plus three counters (index, run, dump) in one file.
- cpu and cpu_loader are instanced side by side in a system top.

Test Plan:
- Stream NI=3 (A,B,C), ND=2 (X,Y), R=0 -> imem writes at byte addrs 0,4,8 and dmem writes at 0,4 with matching data; cpu_enable never high; DUMP_WORDS=16 dump returns X,Y then 14 words of prior contents; done=1.
- NI=0 -> err=1, s_ready=0, no wen ever.
- NI=513 with IMEM_WORDS=512 -> err=1, no wen ever.
- ND=1025 with DMEM_WORDS=1024 -> imem writes complete, then err=1, no dmem write.
- R=5 -> cpu_enable high exactly 5 consecutive cycles, followed by the first dmem_ren.
- Preloaded program (addi/sw storing 42 to dmem word 0), R=20 -> first m_data=42.
- m_ready held low 10 cycles during dump -> m_valid/m_data stable throughout, no extra dmem_ren.
- s_valid gaps (one valid every 3rd cycle) during load -> write count and addresses unchanged.
- Reset asserted mid-LOAD_I after 2 of 4 words -> next cycle all outputs 0, s_ready=1; a fresh frame loads correctly from address 0.
- Reset asserted during RUN -> cpu_enable=0 the cycle after the reset edge.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the cpu boot/run/dump loader: controller states and
// the word-to-byte address conversion used on both memory ports.
package cpu_loader_pkg;

    typedef enum logic [3:0] {
        HDR_I,
        LOAD_I,
        HDR_D,
        LOAD_D,
        HDR_R,
        RUN,
        DUMP_REQ,
        DUMP_CAP,
        DUMP_OUT,
        DONE,
        ERROR
    } state_t;

    localparam int ADDR_SHIFT = 2;

    function automatic logic [31:0] to_byte_addr(input logic [31:0] word_idx);
        return word_idx << ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/cpu_loader.sv
// Host-side loader: writes cpu instruction/data memory from a framed word stream,
// runs the cpu for a host-given cycle count, then streams back the first data words.
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int DUMP_WORDS = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              cpu_enable,
    output logic [31:0]       imem_addr,
    output logic              imem_wen,
    output logic              imem_ren,
    output logic [DATA_W-1:0] imem_wdata,
    output logic [31:0]       dmem_addr,
    output logic              dmem_wen,
    output logic              dmem_ren,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              done,
    output logic              err
);

    localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS) + 1;
    localparam int DMP_W     = $clog2(DUMP_WORDS) + 1;

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [IDX_W-1:0]  n_words, n_words_next;
    logic [DATA_W-1:0] run_cnt, run_cnt_next;
    logic [DMP_W-1:0]  dump_cnt, dump_cnt_next;

    logic xfer;
    logic last_word;

    logic s_ready_d;
    logic m_valid_d;
    logic cpu_enable_d;
    logic imem_wen_d;
    logic dmem_wen_d;
    logic dmem_ren_d;
    logic done_d;
    logic err_d;

    // s_ready is registered from the next state, so it always matches the
    // state that will consume the word on the following edge.
    assign xfer      = s_valid & s_ready;
    assign last_word = (idx == n_words - IDX_W'(1));
    assign imem_ren  = 1'b0;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state    <= HDR_I;
            idx      <= '0;
            n_words  <= '0;
            run_cnt  <= '0;
            dump_cnt <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            n_words  <= n_words_next;
            run_cnt  <= run_cnt_next;
            dump_cnt <= dump_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        n_words_next  = n_words;
        run_cnt_next  = run_cnt;
        dump_cnt_next = dump_cnt;
        unique case (state)
            HDR_I: begin
                if (xfer) begin
                    idx_next = '0;
                    if (s_data == '0 || s_data > DATA_W'(IMEM_WORDS)) begin
                        state_next = ERROR;
                    end else begin
                        n_words_next = IDX_W'(s_data);
                        state_next   = LOAD_I;
                    end
                end
            end
            LOAD_I: begin
                if (xfer) begin
                    if (last_word) begin
                        idx_next   = '0;
                        state_next = HDR_D;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            HDR_D: begin
                if (xfer) begin
                    idx_next = '0;
                    if (s_data > DATA_W'(DMEM_WORDS)) begin
                        state_next = ERROR;
                    end else if (s_data == '0) begin
                        state_next = HDR_R;
                    end else begin
                        n_words_next = IDX_W'(s_data);
                        state_next   = LOAD_D;
                    end
                end
            end
            LOAD_D: begin
                if (xfer) begin
                    if (last_word) begin
                        idx_next   = '0;
                        state_next = HDR_R;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            HDR_R: begin
                if (xfer) begin
                    run_cnt_next  = s_data;
                    dump_cnt_next = '0;
                    state_next    = (s_data == '0) ? DUMP_REQ : RUN;
                end
            end
            RUN: begin
                run_cnt_next = run_cnt - DATA_W'(1);
                if (run_cnt == DATA_W'(1)) begin
                    state_next = DUMP_REQ;
                end
            end
            DUMP_REQ: state_next = DUMP_CAP;
            DUMP_CAP: state_next = DUMP_OUT;
            DUMP_OUT: begin
                if (m_ready) begin
                    dump_cnt_next = dump_cnt + DMP_W'(1);
                    if (dump_cnt_next == DMP_W'(DUMP_WORDS)) begin
                        state_next = DONE;
                    end else begin
                        state_next = DUMP_REQ;
                    end
                end
            end
            default: state_next = state;
        endcase
    end

    // Next values of every registered output, derived from the transition.
    always_comb begin
        s_ready_d    = state_next inside {HDR_I, LOAD_I, HDR_D, LOAD_D, HDR_R};
        imem_wen_d   = (state == LOAD_I) && xfer;
        dmem_wen_d   = (state == LOAD_D) && xfer;
        dmem_ren_d   = (state_next == DUMP_REQ);
        cpu_enable_d = (state_next == RUN);
        m_valid_d    = (state_next == DUMP_OUT);
        done_d       = (state_next == DONE);
        err_d        = (state_next == ERROR);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            m_data     <= '0;
            cpu_enable <= 1'b0;
            imem_addr  <= '0;
            imem_wen   <= 1'b0;
            imem_wdata <= '0;
            dmem_addr  <= '0;
            dmem_wen   <= 1'b0;
            dmem_ren   <= 1'b0;
            dmem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            s_ready    <= s_ready_d;
            m_valid    <= m_valid_d;
            cpu_enable <= cpu_enable_d;
            imem_wen   <= imem_wen_d;
            dmem_wen   <= dmem_wen_d;
            dmem_ren   <= dmem_ren_d;
            done       <= done_d;
            err        <= err_d;
            if (imem_wen_d) begin
                imem_addr  <= to_byte_addr(32'(idx));
                imem_wdata <= s_data;
            end
            // The dmem address is shared by load writes and dump reads.
            if (dmem_wen_d) begin
                dmem_addr  <= to_byte_addr(32'(idx));
                dmem_wdata <= s_data;
            end else if (dmem_ren_d) begin
                dmem_addr <= to_byte_addr(32'(dump_cnt_next));
            end
            if (state == DUMP_CAP) begin
                m_data <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Randomized bench for cpu_loader: a behavioural memory/cpu stand-in plus a
// frame-level reference model predicting writes, run length and dump contents.
module tb_cpu_loader;

    localparam int IMEM = 512;
    localparam int DMEM = 1024;
    localparam int DUMP = 16;

    logic        clk = 1'b0;
    logic        arst_n, s_valid, s_ready, m_valid, m_ready, cpu_enable;
    logic        imem_wen, imem_ren, dmem_wen, dmem_ren, done, err;
    logic [31:0] s_data, m_data, imem_addr, imem_wdata, dmem_addr, dmem_wdata, dmem_rdata;

    always #5 clk = ~clk;

    cpu_loader #(
        .DATA_W(32), .IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM), .DUMP_WORDS(DUMP)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cpu_enable(cpu_enable),
        .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .done(done), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] s, input int i);
        return s ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // Data memory with one-cycle read latency; a stand-in cpu bumps word 0 once per enabled cycle.
    logic [31:0] dmem [DMEM];
    logic [31:0] seed;
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DMEM; i++) dmem[i] <= init_val(seed, i);
        end else begin
            if (dmem_wen) dmem[dmem_addr[11:2]] <= dmem_wdata;
            if (cpu_enable) dmem[0] <= dmem[0] + 32'd1;
        end
        if (dmem_ren) dmem_rdata <= dmem[dmem_addr[11:2]];
    end

    // Passive monitor, sampled on the falling edge.
    logic        mon_clr;
    logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], ren_a[$], dq[$];
    int          en_cnt = 0, en_runs = 0, viol = 0;
    logic        pv = 0, pr = 0, pen = 0, prst = 0;
    logic [31:0] pd = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            iw_a.delete(); iw_d.delete(); dw_a.delete(); dw_d.delete(); ren_a.delete(); dq.delete();
            en_cnt <= 0; en_runs <= 0; viol <= 0;
            pv <= 1'b0; pr <= 1'b0; pen <= 1'b0; prst <= 1'b0; pd <= '0;
        end else begin
            if (imem_wen) begin iw_a.push_back(imem_addr); iw_d.push_back(imem_wdata); end
            if (dmem_wen) begin dw_a.push_back(dmem_addr); dw_d.push_back(dmem_wdata); end
            if (dmem_ren) ren_a.push_back(dmem_addr);
            if (m_valid && m_ready) dq.push_back(m_data);
            if (cpu_enable) en_cnt <= en_cnt + 1;
            if (cpu_enable && !pen) en_runs <= en_runs + 1;
            if ((imem_wen && dmem_wen) || (dmem_wen && dmem_ren)) viol <= viol + 1;
            if (pv && !pr && prst && !(m_valid && m_data == pd)) viol <= viol + 1;
            if (pen && !cpu_enable && prst && !dmem_ren) viol <= viol + 1;
            pv <= m_valid; pr <= m_ready; pd <= m_data; pen <= cpu_enable; prst <= arst_n;
        end
    end

    task automatic start_test();
        seed = $urandom;
        s_valid = 1'b0; m_ready = 1'b0; arst_n = 1'b0; mem_init = 1'b1; mon_clr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_init = 1'b0; mon_clr = 1'b0; arst_n = 1'b1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " s_ready"}, 64'(s_ready), 64'(1));
        chk({tag, " ctl"}, 64'({m_valid, cpu_enable, imem_wen, imem_ren, dmem_wen, dmem_ren, done, err}), 64'(0));
        chk({tag, " addr"}, {imem_addr, dmem_addr}, 64'(0));
        chk({tag, " wdata"}, {imem_wdata, dmem_wdata}, 64'(0));
        chk({tag, " m_data"}, 64'(m_data), 64'(0));
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        int t;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = w;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (s_ready) break;
            @(posedge clk); #1;
        end
        if (t == 100) chk("send_accept", 64'(s_ready), 64'(1));
        else begin @(posedge clk); #1; end
        s_valid = 1'b0;
    endtask

    task automatic run_test(input int tid, input logic [31:0] ni_hdr, input logic [31:0] nd_hdr,
                            input logic [31:0] r, input int gap_mode, input int stall, input bit fresh);
        logic [31:0] frame[$];
        logic [31:0] iw[$];
        logic [31:0] dw[$];
        logic [31:0] exp_dump [DUMP];
        logic [31:0] w;
        bit          ni_ok, nd_ok, exp_err;
        int          budget, stall_left, n_dump;
        string       p;
        p       = $sformatf("t%0d", tid);
        ni_ok   = (ni_hdr != 0) && (ni_hdr <= IMEM);
        nd_ok   = (nd_hdr <= DMEM);
        exp_err = !ni_ok || !nd_ok;

        frame.push_back(ni_hdr);
        if (ni_ok) begin
            for (int j = 0; j < int'(ni_hdr); j++) begin w = $urandom; iw.push_back(w); frame.push_back(w); end
            frame.push_back(nd_hdr);
            if (nd_ok) begin
                for (int j = 0; j < int'(nd_hdr); j++) begin w = $urandom; dw.push_back(w); frame.push_back(w); end
                frame.push_back(r);
            end
        end

        if (fresh) start_test();
        else clear_mon();

        for (int k = 0; k < DUMP; k++) exp_dump[k] = init_val(seed, k);
        for (int k = 0; k < dw.size() && k < DUMP; k++) exp_dump[k] = dw[k];
        exp_dump[0] = exp_dump[0] + r;
        n_dump = exp_err ? 0 : DUMP;

        foreach (frame[i]) send(frame[i], (gap_mode == 2) ? 2 : (gap_mode == 1) ? int'($urandom_range(0, 2)) : 0);

        // Drain with junk on s_valid, which must be ignored from here on.
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        stall_left = stall;
        budget = 0;
        while (!(done || err) && budget < 3000) begin
            if (m_valid && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 3000) chk({p, " finish_in_time"}, 64'(done || err), 64'(1));
        m_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);

        chk({p, " err"}, 64'(err), 64'(exp_err));
        chk({p, " done"}, 64'(done), 64'(!exp_err));
        chk({p, " s_ready"}, 64'(s_ready), 64'(0));
        chk({p, " viol"}, 64'(viol), 64'(0));
        chk({p, " en_cycles"}, 64'(en_cnt), exp_err ? 64'(0) : 64'(r));
        chk({p, " en_runs"}, 64'(en_runs), 64'((!exp_err && r != 0) ? 1 : 0));
        chk({p, " imem_n"}, 64'(iw_a.size()), 64'(iw.size()));
        for (int j = 0; j < iw.size() && j < iw_a.size(); j++) begin
            chk($sformatf("%s imem_addr[%0d]", p, j), 64'(iw_a[j]), 64'(j * 4));
            chk($sformatf("%s imem_data[%0d]", p, j), 64'(iw_d[j]), 64'(iw[j]));
        end
        chk({p, " dmem_n"}, 64'(dw_a.size()), 64'(exp_err ? 0 : dw.size()));
        for (int j = 0; j < dw.size() && j < dw_a.size(); j++) begin
            chk($sformatf("%s dmem_addr[%0d]", p, j), 64'(dw_a[j]), 64'(j * 4));
            chk($sformatf("%s dmem_data[%0d]", p, j), 64'(dw_d[j]), 64'(dw[j]));
        end
        chk({p, " ren_n"}, 64'(ren_a.size()), 64'(n_dump));
        for (int k = 0; k < n_dump && k < ren_a.size(); k++)
            chk($sformatf("%s ren_addr[%0d]", p, k), 64'(ren_a[k]), 64'(k * 4));
        chk({p, " dump_n"}, 64'(dq.size()), 64'(n_dump));
        for (int k = 0; k < n_dump && k < dq.size(); k++)
            chk($sformatf("%s dump[%0d]", p, k), 64'(dq[k]), 64'(exp_dump[k]));
    endtask

    initial begin
        int t;
        arst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        mem_init = 1'b1; mon_clr = 1'b1; seed = '0;

        start_test();
        @(negedge clk);
        check_idle("rst");

        run_test(1, 3, 2, 0, 0, 0, 1);
        run_test(2, 0, 0, 7, 0, 0, 1);
        run_test(3, 513, 0, 7, 0, 0, 1);
        run_test(4, 3, 1025, 7, 0, 0, 1);
        run_test(5, 4, 3, 5, 1, 0, 1);
        run_test(6, 2, 1, 3, 0, 10, 1);
        run_test(7, 6, 4, 2, 2, 0, 1);
        run_test(8, 512, 0, 1, 0, 0, 1);
        run_test(9, 1, 1024, 0, 0, 0, 1);

        // Reset after 2 of 4 instruction words, then a fresh frame from address 0.
        start_test();
        send(32'd4, 0);
        send($urandom, 0);
        send($urandom, 0);
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("t10 rst");
        @(posedge clk); #1;
        arst_n = 1'b1;
        run_test(10, 4, 2, 3, 1, 0, 0);

        // Reset while the cpu is running.
        start_test();
        send(32'd2, 0); send($urandom, 0); send($urandom, 0);
        send(32'd1, 0); send($urandom, 0); send(32'd20, 0);
        for (t = 0; t < 50; t++) begin
            if (cpu_enable) break;
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("t11 enable_before_rst", 64'(cpu_enable), 64'(1));
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("t11 rst");
        @(posedge clk); #1;
        arst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_test(20 + i, $urandom_range(1, 24), $urandom_range(0, 20), $urandom_range(0, 30),
                     $urandom_range(0, 2), $urandom_range(0, 6), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
